// File: rtl/store_align_buffer_if.sv
// store_align_buffer_if: store-in, memory-write-out and load-conflict signals of the store buffer.
interface store_align_buffer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic [2:0]        st_func3;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready;
  logic              mem_wreq;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wbe;
  logic              mem_wack;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_conflict;
  logic              sb_empty;
  logic              misalign;
  modport master (
    output st_valid, st_func3, st_addr, st_data, mem_wack, ld_addr,
    input  st_ready, mem_wreq, mem_waddr, mem_wdata, mem_wbe, ld_conflict, sb_empty, misalign
  );
  modport slave (
    input  st_valid, st_func3, st_addr, st_data, mem_wack, ld_addr,
    output st_ready, mem_wreq, mem_waddr, mem_wdata, mem_wbe, ld_conflict, sb_empty, misalign
  );
endinterface

// File: rtl/store_align_buffer.sv
// store_align_buffer: aligns SB/SH/SW stores, queues them in a FIFO and drains them over req/ack.
// Optional STORE_MISALIGN_CHK_EN drops misaligned SH/SW and pulses misalign.
module store_align_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  store_align_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] F_SB = 3'b000;
  localparam logic [2:0] F_SH = 3'b001;
  localparam logic [2:0] F_SW = 3'b010;
  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [3:0]        wbe_q   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, slot;
  logic [CW-1:0]     count;
  logic [1:0]        a;
  logic              legal, mis, push, pop, empty, conflict;
  logic [31:0]       al_data;
  logic [3:0]        al_be;
  assign a     = bus.st_addr[1:0];
  assign legal = (bus.st_func3 == F_SB) || (bus.st_func3 == F_SH) || (bus.st_func3 == F_SW);
  assign empty = (count == '0);
  assign push  = bus.st_valid && bus.st_ready && legal && !mis;
  assign pop   = bus.mem_wreq && bus.mem_wack;
  always_comb begin
    al_data = (bus.st_func3 == F_SB) ? {4{bus.st_data[7:0]}} :
              (bus.st_func3 == F_SH) ? {2{bus.st_data[15:0]}} : bus.st_data;
    al_be   = (bus.st_func3 == F_SB) ? (4'b0001 << a) :
              (bus.st_func3 == F_SH) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
`ifdef STORE_MISALIGN_CHK_EN
  logic mis_q;
  assign mis = ((bus.st_func3 == F_SH) && a[0]) || ((bus.st_func3 == F_SW) && (a != 2'b00));
  always_ff @(posedge clk)
    mis_q <= rst ? 1'b0 : (bus.st_valid && bus.st_ready && legal && mis);
  assign bus.misalign = mis_q;
`else
  assign mis          = 1'b0;
  assign bus.misalign = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr] <= {bus.st_addr[ADDR_W-1:2], 2'b00};
      wdata_q[wr_ptr] <= al_data;
      wbe_q[wr_ptr]   <= al_be;
    end
  end
  // walk occupied slots from the head; the store entering this cycle is not yet visible
  always_comb begin
    conflict = 1'b0;
    slot     = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      slot     = rd_ptr + PW'(k);
      conflict = conflict || ((CW'(k) < count) &&
                 (waddr_q[slot][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]));
    end
  end
  assign bus.ld_conflict = conflict;
  assign bus.st_ready    = (count != CW'(DEPTH));
  assign bus.sb_empty    = empty;
  assign bus.mem_wreq    = !empty;
  assign bus.mem_waddr   = empty ? '0 : waddr_q[rd_ptr];
  assign bus.mem_wdata   = empty ? '0 : wdata_q[rd_ptr];
  assign bus.mem_wbe     = empty ? '0 : wbe_q[rd_ptr];
endmodule
